uart_rxd: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart of uart_txd on the same RS-232 link.
- Synchronises the asynchronous serial line and validates the start bit at mid-bit.
- Samples 8 data bits LSB-first, then checks the stop bit.
- Presents the byte with a one-cycle done pulse, or flags a framing error.
- Self-timed: an internal bit counter derived from CLKS_PER_BIT, so no baudrate_gen tick is needed.

---
 rtl/uart_rxd.sv | 135 +++++++++++++
 tb/tb_uart_rxd.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rxd.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit start validation,
// LSB-first data capture, stop-bit check with break handling.
module uart_rxd #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rs232_rxd,
  output logic [7:0] o_data,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_rx_busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK_WAIT
  } state_t;

  state_t           state;
  logic             rx_s1;
  logic             rx_s2;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       sh;
  logic             ok_q;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      cnt         <= '0;
      bit_idx     <= '0;
      sh          <= '0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      o_data      <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      o_rx_busy   <= 1'b0;
    end else begin
      rx_s1 <= i_rs232_rxd;
      rx_s2 <= rx_s1;

      // Stop-bit verdict passes through one more register so the pulse and
      // o_data land together one cycle after the stop-bit sample.
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      o_rx_done   <= ok_q;
      o_frame_err <= err_q;
      if (ok_q) begin
        o_data <= sh;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s2) begin
            state     <= START;
            o_rx_busy <= 1'b1;
          end
        end

        START: begin
          if (cnt == CNT_HALF_LAST) begin
            cnt <= '0;
            if (!rx_s2) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state     <= IDLE;
              o_rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == CNT_BIT_LAST) begin
            cnt     <= '0;
            sh      <= {rx_s2, sh[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt == CNT_BIT_LAST) begin
            cnt <= '0;
            if (rx_s2) begin
              ok_q      <= 1'b1;
              state     <= IDLE;
              o_rx_busy <= 1'b0;
            end else begin
              err_q <= 1'b1;
              state <= BRK_WAIT;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        BRK_WAIT: begin
          cnt <= '0;
          if (rx_s2) begin
            state     <= IDLE;
            o_rx_busy <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          cnt       <= '0;
          o_rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rxd.sv
// Randomised and directed bench for uart_rxd; a time-based line decoder
// predicts every output cycle by cycle.
module tb_uart_rxd;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LEN  = 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_rx_busy;

  uart_rxd #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rs232_rxd (rxd),
    .o_data      (o_data),
    .o_rx_done   (o_rx_done),
    .o_frame_err (o_frame_err),
    .o_rx_busy   (o_rx_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 2;
  bit checking = 1'b0;
  int last_e0;

  bit line [0:LEN-1];
  initial for (int i = 0; i < LEN; i++) line[i] = 1'b1;

  // Model state: expected outputs after the edge just processed.
  logic       e_done, e_err, e_busy;
  logic [7:0] e_data;
  bit         active, brk, pend_ok, pend_err;
  logic [7:0] pend_byte;
  int         t0, free_from;

  int         dut_edge[$];
  logic [7:0] dut_byte[$];
  int         dut_err[$];
  int         mdl_edge[$];
  logic [7:0] mdl_byte[$];

  // Line value seen by the receiver at edge k is line[k-2]; a frame whose
  // line first goes low at index t0 is sampled at t0+HALF+n*CPB.
  always @(posedge clk) begin
    int k;
    logic [7:0] b;
    k = cyc;
    if (k >= LEN - 1) begin
      $display("FAIL cycle_budget got=%0d limit=%0d", k, LEN - 1);
      $fatal(1);
    end
    line[k] = rxd;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (rst) begin
      active = 0; brk = 0; pend_ok = 0; pend_err = 0;
      e_busy = 1'b0; e_data = 8'h00;
      free_from = k + 1;
    end else begin
      if (pend_ok) begin
        e_done = 1'b1;
        e_data = pend_byte;
        mdl_edge.push_back(k);
        mdl_byte.push_back(pend_byte);
      end
      if (pend_err) e_err = 1'b1;
      pend_ok = 0; pend_err = 0;
      if (brk) begin
        if (line[k-2]) begin
          brk = 0; e_busy = 1'b0; free_from = k - 1;
        end
      end else if (active) begin
        if (k == t0 + 2 + HALF && line[t0 + HALF]) begin
          active = 0; e_busy = 1'b0; free_from = k - 1;
        end else if (k == t0 + 2 + HALF + 9 * CPB) begin
          for (int i = 0; i < 8; i++) b[i] = line[t0 + HALF + (i + 1) * CPB];
          active = 0;
          if (line[t0 + HALF + 9 * CPB]) begin
            pend_ok = 1; pend_byte = b; e_busy = 1'b0; free_from = k - 1;
          end else begin
            pend_err = 1; brk = 1;
          end
        end
      end else if (k - 2 >= free_from && !line[k-2]) begin
        active = 1; t0 = k - 2; e_busy = 1'b1;
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (checking) begin
      n_tests++;
      if ({o_rx_done, o_frame_err, o_rx_busy, o_data} !== {e_done, e_err, e_busy, e_data}) begin
        n_fail++;
        $display("FAIL cycle_%0d done/err/busy/data got=%b/%b/%b/%h exp=%b/%b/%b/%h",
                 cyc - 1, o_rx_done, o_frame_err, o_rx_busy, o_data,
                 e_done, e_err, e_busy, e_data);
      end
      if (o_rx_done === 1'b1) begin
        dut_edge.push_back(cyc - 1);
        dut_byte.push_back(o_data);
      end
      if (o_frame_err === 1'b1) dut_err.push_back(cyc - 1);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic int qi(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  function automatic int qb(input logic [7:0] q[$], input int idx);
    return (idx < q.size()) ? int'(q[idx]) : -1;
  endfunction

  task automatic clear_q();
    dut_edge.delete(); dut_byte.delete(); dut_err.delete();
    mdl_edge.delete(); mdl_byte.delete();
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; each bit occupies exactly CPB rising edges.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit);
    rxd = 1'b0;
    last_e0 = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    int e0a, e0b, n;
    repeat (3) @(negedge clk);
    checking = 1'b1;
    chk("reset_data", int'(o_data), 0);
    chk("reset_busy", int'(o_rx_busy), 0);
    rst = 1'b0;
    idle(10);

    // 1: single frame latency and data
    clear_q();
    send_frame(8'hA5, 1'b1);
    e0a = last_e0;
    idle(20);
    chk("t1_done_count", dut_edge.size(), 1);
    chk("t1_done_edge", qi(dut_edge, 0) - e0a, 155);
    chk("t1_data", qb(dut_byte, 0), 8'hA5);
    chk("t1_model_edge", qi(mdl_edge, 0) - e0a, 155);
    chk("t1_model_data", qb(mdl_byte, 0), 8'hA5);
    chk("t1_err_count", dut_err.size(), 0);

    // 2: back-to-back with zero idle gap
    clear_q();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    chk("t2_done_count", dut_edge.size(), 2);
    chk("t2_spacing", qi(dut_edge, 1) - qi(dut_edge, 0), 160);
    chk("t2_data0", qb(dut_byte, 0), 8'h00);
    chk("t2_data1", qb(dut_byte, 1), 8'hFF);

    // 3: short glitch
    clear_q();
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    chk("t3_done_count", dut_edge.size(), 0);
    chk("t3_err_count", dut_err.size(), 0);
    chk("t3_data_kept", int'(o_data), 8'hFF);

    // 4: framing error, then recovery
    clear_q();
    send_frame(8'h3C, 1'b1);
    idle(5);
    send_frame(8'h5A, 1'b0);
    repeat (CPB) @(negedge clk);
    idle(20);
    chk("t4_err_count", dut_err.size(), 1);
    chk("t4_data_kept", int'(o_data), 8'h3C);
    send_frame(8'h81, 1'b1);
    idle(20);
    chk("t4_done_count", dut_edge.size(), 2);
    chk("t4_data_after", qb(dut_byte, 1), 8'h81);

    // 5: break condition
    clear_q();
    rxd = 1'b0;
    repeat (400) @(negedge clk);
    rxd = 1'b1;
    n = 0;
    while (o_rx_busy === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t5_busy_release", n, 3);
    idle(20);
    chk("t5_err_count", dut_err.size(), 1);
    chk("t5_done_count", dut_edge.size(), 0);

    // 6: reset during data bit 4
    clear_q();
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (5 * CPB + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_data", int'(o_data), 0);
        chk("t6_rst_busy", int'(o_rx_busy), 0);
        rst = 1'b0;
      end
    join
    chk("t6_no_done", dut_edge.size(), 0);
    chk("t6_no_err", dut_err.size(), 0);
    idle(200);
    clear_q();
    send_frame(8'h12, 1'b1);
    e0b = last_e0;
    idle(20);
    chk("t6_next_count", dut_edge.size(), 1);
    chk("t6_next_data", qb(dut_byte, 0), 8'h12);
    chk("t6_next_edge", qi(dut_edge, 0) - e0b, 155);

    // Random traffic: good frames, bad stop bits, glitches, random gaps
    for (int it = 0; it < 24; it++) begin
      int kind;
      kind = $urandom % 8;
      if (kind == 0) begin
        rxd = 1'b0;
        repeat ($urandom_range(1, 12)) @(negedge clk);
      end else if (kind == 1) begin
        send_frame(8'($urandom), 1'b0);
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end else begin
        send_frame(8'($urandom), 1'b1);
      end
      idle($urandom_range(0, 40));
    end
    idle(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
